mesi_isc_mbus_rr_arb: RTL and testbench

//  Round-robin arbiter that shares the single main-bus command path of mesi_isc between the
//  CPU-side masters (mbus_cmd/addr per CPU). Selects one pending master, latches its
//  cmd/addr, presents it downstream with a valid/ready handshake, and returns a 1-cycle

---
 rtl/mesi_isc_mbus_rr_arb.sv | 88 ++++++++
 tb/tb_mesi_isc_mbus_rr_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_mbus_rr_arb.sv
// mesi_isc_mbus_rr_arb: round-robin arbiter sharing the mesi_isc main-bus command path
// between CPU masters, with a valid/ready downstream handshake, 1-cycle ack and grant watchdog.
module mesi_isc_mbus_rr_arb #(
    parameter int N_MASTERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_WIDTH  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS*CMD_WIDTH-1:0]  mbus_cmd_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] mbus_addr_i,
    output logic [N_MASTERS-1:0]            mbus_ack_o,
    output logic                            arb_valid_o,
    input  logic                            arb_ready_i,
    output logic [CMD_WIDTH-1:0]            arb_cmd_o,
    output logic [ADDR_WIDTH-1:0]           arb_addr_o,
    output logic [$clog2(N_MASTERS)-1:0]    arb_id_o,
    output logic                            timeout_o
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2, RELEASE = 2'd3;

    logic [1:0]           state;
    logic [IW-1:0]        rr_ptr;
    logic [WW-1:0]        wdog;
    logic [N_MASTERS-1:0] pend;
    logic [IW-1:0]        win;
    logic                 any;

    // Scan from the farthest offset down so the nearest pending master after rr_ptr wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = 0; k < N_MASTERS; k++)
            pend[k] = mbus_cmd_i[k*CMD_WIDTH +: CMD_WIDTH] != '0;
        for (int i = N_MASTERS; i >= 1; i--)
            if (pend[(int'(rr_ptr) + i) % N_MASTERS]) begin
                win = IW'((int'(rr_ptr) + i) % N_MASTERS);
                any = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= IW'(N_MASTERS - 1);
            wdog        <= '0;
            mbus_ack_o  <= '0;
            arb_valid_o <= 1'b0;
            arb_cmd_o   <= '0;
            arb_addr_o  <= '0;
            arb_id_o    <= '0;
            timeout_o   <= 1'b0;
        end else begin
            mbus_ack_o <= '0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    state       <= GRANT;
                    arb_valid_o <= 1'b1;
                    arb_cmd_o   <= mbus_cmd_i[win*CMD_WIDTH +: CMD_WIDTH];
                    arb_addr_o  <= mbus_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                    arb_id_o    <= win;
                    wdog        <= '0;
                end
                GRANT: if (arb_ready_i) begin
                    state       <= ACK;
                    arb_valid_o <= 1'b0;
                    mbus_ack_o  <= N_MASTERS'(1) << arb_id_o;
                    rr_ptr      <= arb_id_o;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    state       <= IDLE;
                    arb_valid_o <= 1'b0;
                    timeout_o   <= 1'b1;
                    rr_ptr      <= arb_id_o;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                ACK: state <= RELEASE;
                // Hold off all grants until the winner withdraws its stale command.
                RELEASE: if (mbus_cmd_i[arb_id_o*CMD_WIDTH +: CMD_WIDTH] == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesi_isc_mbus_rr_arb.sv
// tb_mesi_isc_mbus_rr_arb: directed and random rounds; the driver predicts each grant from
// the pending set and last winner, a negedge monitor pops and checks what the arbiter presents.
module tb_mesi_isc_mbus_rr_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int CW = 3;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*CW-1:0] mbus_cmd_i;
    logic [N*AW-1:0] mbus_addr_i;
    logic [N-1:0]    mbus_ack_o;
    logic            arb_valid_o;
    logic            arb_ready_i = 1'b0;
    logic [CW-1:0]   arb_cmd_o;
    logic [AW-1:0]   arb_addr_o;
    logic [1:0]      arb_id_o;
    logic            timeout_o;

    mesi_isc_mbus_rr_arb #(.N_MASTERS(N), .ADDR_WIDTH(AW), .CMD_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mbus_cmd_i(mbus_cmd_i), .mbus_addr_i(mbus_addr_i),
        .mbus_ack_o(mbus_ack_o), .arb_valid_o(arb_valid_o), .arb_ready_i(arb_ready_i),
        .arb_cmd_o(arb_cmd_o), .arb_addr_o(arb_addr_o), .arb_id_o(arb_id_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        int            d;
    } exp_t;

    exp_t          q[$];
    exp_t          cur;
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] mc[N];
    logic [AW-1:0] ma[N];
    int            last = N - 1;
    int            drop_id = -1;
    int            cur_w = -1;
    bit            active = 1'b0;
    bit            pv = 1'b0;
    int            vcnt = 0;

    always_comb begin
        mbus_cmd_i  = '0;
        mbus_addr_i = '0;
        for (int k = 0; k < N; k++) begin
            mbus_cmd_i[k*CW +: CW]  = mc[k];
            mbus_addr_i[k*AW +: AW] = ma[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference arbitration: first master with a live command after the last winner, modulo N.
    function automatic int pick();
        for (int i = 1; i <= N; i++)
            if (mc[(last + i) % N] != '0) return (last + i) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        arb_ready_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            mc[k] = '0;
            ma[k] = '0;
        end
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", arb_valid_o, 0);
        chk("rst_ack", mbus_ack_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_cmd_addr_id", {arb_cmd_o, arb_addr_o, arb_id_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        last = N - 1;
        drop_id = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [N-1:0] add, input int d, input logic [CW-1:0] fcmd,
                               input logic [AW-1:0] faddr);
        if (drop_id >= 0) mc[drop_id] = '0;
        for (int k = 0; k < N; k++)
            if (add[k] && k != drop_id && mc[k] == '0) begin
                mc[k] = (fcmd != '0) ? fcmd : CW'($urandom_range(1, 4));
                ma[k] = (fcmd != '0) ? faddr : AW'($urandom);
            end
        drop_id = -1;
        cur_w = pick();
        if (cur_w >= 0) q.push_back('{cur_w, mc[cur_w], ma[cur_w], d});
    endtask

    task automatic run_grant(input int d, input bit may_drop);
        int n;
        int v;
        if (cur_w < 0) return;
        n = 0;
        while (!arb_valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!arb_valid_o) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: no arb_valid_o within 20 cycles, required grant to %0d", cur_w);
            last = cur_w;
            drop_id = cur_w;
            return;
        end
        v = 0;
        while (arb_valid_o && v < 20) begin
            arb_ready_i = (v == d);
            if (may_drop && v == 0 && $urandom_range(0, 3) == 0) mc[cur_w] = '0;
            @(posedge clk);
            #1;
            arb_ready_i = 1'b0;
            v++;
        end
        if (arb_valid_o) begin
            checks++;
            errors++;
            $display("FAIL grant_end: arb_valid_o still 1 after 20 cycles, required drop");
        end
        last = cur_w;
        if (mbus_ack_o != '0) begin
            drop_id = cur_w;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end else begin
            drop_id = -1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            active = 1'b0;
            pv = 1'b0;
        end else begin
            if (arb_valid_o && mbus_ack_o != '0) chk("valid_ack_overlap", 1, 0);
            if (arb_valid_o && !pv) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", arb_id_o, 64'hffff);
                end else begin
                    cur = q.pop_front();
                    active = 1'b1;
                    vcnt = 1;
                    chk("grant_id", arb_id_o, cur.id);
                    chk("grant_cmd", arb_cmd_o, cur.cmd);
                    chk("grant_addr", arb_addr_o, cur.addr);
                end
            end else if (arb_valid_o) begin
                vcnt++;
                if (active) chk("grant_stable", {arb_id_o, arb_cmd_o, arb_addr_o}, {cur.id[1:0], cur.cmd, cur.addr});
            end
            if (mbus_ack_o != '0) begin
                if (!active) begin
                    chk("spurious_ack", mbus_ack_o, 0);
                end else begin
                    chk("ack_onehot", mbus_ack_o, N'(1) << cur.id);
                    chk("ack_not_timeout", cur.d < TO, 1);
                    chk("ack_valid_cycles", vcnt, cur.d + 1);
                    active = 1'b0;
                end
            end
            if (timeout_o) begin
                if (!active) begin
                    chk("spurious_timeout", timeout_o, 0);
                end else begin
                    chk("timeout_expected", cur.d >= TO, 1);
                    chk("timeout_valid_cycles", vcnt, TO);
                    active = 1'b0;
                end
            end
            pv = arb_valid_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        do_reset();
        // Single RD from master 2.
        start_round(4'b0100, 0, 3'd2, 32'h1234_5678);
        run_grant(0, 1'b0);
        // All four request after reset: order 0,1,2,3.
        do_reset();
        start_round(4'b1111, 0, '0, '0);
        run_grant(0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            start_round(4'b0000, 0, '0, '0);
            run_grant(0, 1'b0);
        end
        // Masters 1 and 3 keep re-requesting.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            start_round(4'b1010, 0, '0, '0);
            run_grant(0, 1'b0);
        end
        // Watchdog drop of master 0, then master 1 is served.
        do_reset();
        start_round(4'b0011, 9, '0, '0);
        run_grant(9, 1'b0);
        start_round(4'b0000, 0, '0, '0);
        run_grant(0, 1'b0);
        // Ready on the final watchdog cycle: ack wins.
        start_round(4'b0000, TO - 1, '0, '0);
        run_grant(TO - 1, 1'b0);
        // Randomised traffic.
        for (int r = 0; r < 40; r++) begin
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
            start_round(N'($urandom_range(0, 15)), d, '0, '0);
            run_grant(d, 1'b1);
        end
        // Asynchronous reset in the middle of a grant.
        do_reset();
        start_round(4'b0100, 0, '0, '0);
        while (!arb_valid_o) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", arb_valid_o, 0);
        chk("async_rst_ack_timeout", {mbus_ack_o, timeout_o}, 0);
        chk("async_rst_cmd_addr_id", {arb_cmd_o, arb_addr_o, arb_id_o}, 0);
        q.delete();
        for (int k = 0; k < N; k++) mc[k] = '0;
        mc[0] = 3'd1;
        ma[0] = 32'hA0A0_0000;
        mc[3] = 3'd4;
        ma[3] = 32'hB3B3_0003;
        last = N - 1;
        drop_id = -1;
        @(negedge clk);
        rst = 1'b1;
        start_round(4'b0000, 0, '0, '0);
        run_grant(0, 1'b0);
        start_round(4'b0000, 0, '0, '0);
        run_grant(0, 1'b0);
        start_round(4'b0000, 0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
